mult_acc_pipe: RTL and testbench

- Parametrised pipelined multiply / multiply-accumulate unit; next generation of the team's fixed 18x18 four-stage pipelined multiplier.
- Adds configurable operand widths and pipeline depth, per-transaction signed/unsigned mode, optional accumulation, valid/ready flow control with full-pipeline stall, and an overflow flag.
- Sits between DSP datapath producers and consumers that may apply backpressure.

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_pipe_stage.sv | 34 +++
 rtl/mult_acc_pipe.sv | 152 +++++++++++++++
 tb/tb_mult_acc_pipe.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the pipelined multiply / multiply-accumulate unit.
package mult_pkg;

    function automatic int prod_width(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    // Per-beat control carried alongside the product through the pipe.
    typedef struct packed {
        logic sgn;
        logic acc;
    } beat_ctrl_t;

endpackage

// File: rtl/mult_pipe_stage.sv
// One stallable pipeline register: valid bit is reset, payload is not.
module mult_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (en_i) begin
            valid_q <= valid_i;
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) begin
            data_q <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mult_acc_pipe.sv
// Pipelined multiply / multiply-accumulate with whole-pipe stall on backpressure.
// Handshake: a beat moves on an edge where valid && ready; ready never depends on valid.
module mult_acc_pipe
    import mult_pkg::*;
#(
    parameter int A_W         = 18,
    parameter int B_W         = 18,
    parameter int PIPE_STAGES = 4,
    parameter int ACC_W       = 48
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    input  logic             in_signed,
    input  logic             in_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int P_W = prod_width(A_W, B_W);

    typedef struct packed {
        logic [P_W-1:0] product;
        beat_ctrl_t     ctrl;
    } stage_payload_t;

    localparam int PL_W = $bits(stage_payload_t);

    logic advance;

    logic             in_vld_q;
    logic [A_W-1:0]   a_q;
    logic [B_W-1:0]   b_q;
    beat_ctrl_t       in_ctrl_q;

    logic [P_W-1:0]   a_ext, b_ext, product;
    stage_payload_t   pl_in;

    logic [PL_W-1:0]        stg_data [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] stg_vld;
    stage_payload_t         last;

    logic [ACC_W-1:0] ext;
    logic [ACC_W:0]   sum_full;
    logic             ovf_acc;
    logic [ACC_W-1:0] out_data_d;
    logic             out_ovf_d;

    logic             out_valid_q;
    logic [ACC_W-1:0] out_data_q;
    logic             out_ovf_q;

    assign advance  = !out_valid_q || out_ready;
    assign in_ready = advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_vld_q <= 1'b0;
        end else if (advance) begin
            in_vld_q <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            a_q           <= in_a;
            b_q           <= in_b;
            in_ctrl_q.sgn <= in_signed;
            in_ctrl_q.acc <= in_acc;
        end
    end

    // Extending both operands to P_W and keeping the low P_W bits gives the
    // correct product for either signedness.
    always_comb begin
        a_ext = P_W'(a_q);
        b_ext = P_W'(b_q);
        if (in_ctrl_q.sgn && a_q[A_W-1]) a_ext[P_W-1:A_W] = '1;
        if (in_ctrl_q.sgn && b_q[B_W-1]) b_ext[P_W-1:B_W] = '1;
        product = a_ext * b_ext;
    end

    assign pl_in = {product, in_ctrl_q};

    for (genvar g = 0; g < PIPE_STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            mult_pipe_stage #(.W(PL_W)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .en_i    (advance),
                .valid_i (in_vld_q),
                .data_i  (pl_in),
                .valid_o (stg_vld[g]),
                .data_o  (stg_data[g])
            );
        end else begin : g_rest
            mult_pipe_stage #(.W(PL_W)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .en_i    (advance),
                .valid_i (stg_vld[g-1]),
                .data_i  (stg_data[g-1]),
                .valid_o (stg_vld[g]),
                .data_o  (stg_data[g])
            );
        end
    end

    assign last = stg_data[PIPE_STAGES-1];

    always_comb begin
        ext = '0;
        ext[P_W-1:0] = last.product;
        for (int i = P_W; i < ACC_W; i++) begin
            ext[i] = last.ctrl.sgn & last.product[P_W-1];
        end
        sum_full = {1'b0, out_data_q} + {1'b0, ext};
        if (last.ctrl.sgn) begin
            ovf_acc = (out_data_q[ACC_W-1] == ext[ACC_W-1]) &&
                      (sum_full[ACC_W-1] != out_data_q[ACC_W-1]);
        end else begin
            ovf_acc = sum_full[ACC_W];
        end
        out_data_d = last.ctrl.acc ? sum_full[ACC_W-1:0] : ext;
        out_ovf_d  = last.ctrl.acc ? ovf_acc : 1'b0;
    end

    // Bubbles clear out_valid but leave the accumulator untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else if (advance) begin
            out_valid_q <= stg_vld[PIPE_STAGES-1];
            if (stg_vld[PIPE_STAGES-1]) begin
                out_data_q <= out_data_d;
                out_ovf_q  <= out_ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mult_acc_pipe.sv
// Self-checking bench: two instances (48-bit and 36-bit accumulator) checked
// against an arithmetic reference model through per-instance expected queues.
module tb_mult_acc_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [17:0] in_a      [2];
    logic [17:0] in_b      [2];
    logic        in_signed [2];
    logic        in_acc    [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic        out_ovf   [2];
    logic [47:0] out_data0;
    logic [35:0] out_data1;

    mult_acc_pipe #(.A_W(18), .B_W(18), .PIPE_STAGES(4), .ACC_W(48)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_a      (in_a[0]),
        .in_b      (in_b[0]),
        .in_signed (in_signed[0]),
        .in_acc    (in_acc[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_data  (out_data0),
        .out_ovf   (out_ovf[0])
    );

    mult_acc_pipe #(.A_W(18), .B_W(18), .PIPE_STAGES(4), .ACC_W(36)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_a      (in_a[1]),
        .in_b      (in_b[1]),
        .in_signed (in_signed[1]),
        .in_acc    (in_acc[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_data  (out_data1),
        .out_ovf   (out_ovf[1])
    );

    int checks = 0;
    int failures = 0;

    logic [48:0] exp_q0[$];
    logic [48:0] exp_q1[$];
    longint      model_acc [2];

    logic [47:0] hold_data   [2];
    bit          was_stalled [2];
    bit          rand_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] get_data(input int id);
        return (id == 0) ? out_data0 : {12'b0, out_data1};
    endfunction

    // Reference: result = ext(a*b) or prev + ext(a*b), modulo 2^W, with
    // overflow judged on the true integer sum.
    task automatic push_expected(input int id, input logic [17:0] a, input logic [17:0] b,
                                 input logic sgn, input logic acc);
        longint w, modv, mask, half, pa, pb, prod, ext, prev, total, res, ps, es, s;
        logic ovf;
        w    = (id == 0) ? 48 : 36;
        modv = longint'(1) << w;
        mask = modv - 1;
        half = modv >> 1;
        pa   = sgn ? longint'($signed(a)) : longint'(a);
        pb   = sgn ? longint'($signed(b)) : longint'(b);
        prod = pa * pb;
        ext  = prod & mask;
        prev = model_acc[id];
        if (!acc) begin
            res = ext;
            ovf = 1'b0;
        end else begin
            total = prev + ext;
            res   = total & mask;
            if (sgn) begin
                ps  = (prev >= half) ? prev - modv : prev;
                es  = (ext >= half) ? ext - modv : ext;
                s   = ps + es;
                ovf = (s >= half) || (s < -half);
            end else begin
                ovf = (total >= modv);
            end
        end
        model_acc[id] = res;
        if (id == 0) exp_q0.push_back({ovf, res[47:0]});
        else         exp_q1.push_back({ovf, res[47:0]});
    endtask

    task automatic monitor(input int id);
        logic [47:0] d;
        logic [48:0] e;
        int          qsz;
        d = get_data(id);
        check($sformatf("in_ready%0d", id), 64'(in_ready[id]), 64'(!out_valid[id] || out_ready[id]));
        if (was_stalled[id]) begin
            check($sformatf("stall_valid%0d", id), 64'(out_valid[id]), 64'(1));
            check($sformatf("stall_data%0d", id), 64'(d), 64'(hold_data[id]));
        end
        if (out_valid[id] && out_ready[id]) begin
            qsz = (id == 0) ? exp_q0.size() : exp_q1.size();
            if (qsz == 0) begin
                check($sformatf("unexpected_out%0d", id), 64'(1), 64'(0));
            end else begin
                e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check($sformatf("result%0d", id), 64'({out_ovf[id], d}), 64'(e));
            end
        end
        was_stalled[id] = out_valid[id] && !out_ready[id];
        hold_data[id]   = d;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            was_stalled[0] = 1'b0;
            was_stalled[1] = 1'b0;
        end else begin
            monitor(0);
            monitor(1);
        end
    end

    // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
    task automatic send(input int id, input logic [17:0] a, input logic [17:0] b,
                        input logic sgn, input logic acc);
        bit ok;
        ok = 1'b0;
        in_valid[id]  = 1'b1;
        in_a[id]      = a;
        in_b[id]      = b;
        in_signed[id] = sgn;
        in_acc[id]    = acc;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready[id];
            @(posedge clk);
            #1;
        end
        in_valid[id] = 1'b0;
        if (ok) push_expected(id, a, b, sgn, acc);
        else    check("send_timeout", 64'(0), 64'(1));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_empty", 64'(exp_q0.size() + exp_q1.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] rand_op();
        logic [17:0] v;
        case ($urandom_range(0, 5))
            0: v = 18'h3FFFF;
            1: v = 18'h20000;
            2: v = 18'h1FFFF;
            3: v = 18'h0;
            default: v = 18'($urandom);
        endcase
        return v;
    endfunction

    task automatic random_stream(input int id, input int n);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(id, rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin
        int drive_cyc;
        int k;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; in_a[i] = '0; in_b[i] = '0;
            in_signed[i] = 1'b0; in_acc[i] = 1'b0; out_ready[i] = 1'b1;
            model_acc[i] = 0;
        end
        rand_done = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid[0]), 64'(0));
        check("rst_out_data", 64'(out_data0), 64'(0));
        check("rst_out_ovf", 64'(out_ovf[0]), 64'(0));
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", 64'(in_ready[0]), 64'(1));

        // Latency and basic unsigned product.
        drive_cyc = cyc;
        send(0, 18'd3, 18'd5, 1'b0, 1'b0);
        k = 0;
        while (!out_valid[0] && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("latency", 64'(cyc - drive_cyc), 64'(6));
        check("basic_data", 64'(out_data0), 64'(15));
        check("basic_ovf", 64'(out_ovf[0]), 64'(0));
        drain();

        // Signed vs unsigned interpretation of the same bits.
        send(0, 18'h3FFFE, 18'd7, 1'b1, 1'b0);
        send(0, 18'h3FFFE, 18'd7, 1'b0, 1'b0);
        drain();

        // Back-to-back accumulate chain.
        send(0, 18'd2, 18'd3, 1'b0, 1'b0);
        send(0, 18'd4, 18'd5, 1'b0, 1'b1);
        send(0, 18'd1, 18'd1, 1'b0, 1'b1);
        k = 0;
        while (!out_valid[0] && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        for (int j = 0; j < 2; j++) begin
            @(posedge clk);
            #1;
            check("chain_consecutive", 64'(out_valid[0]), 64'(1));
        end
        drain();

        // Backpressure mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(0, 18'($urandom), 18'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (8) @(posedge clk);
                #1 out_ready[0] = 1'b0;
                repeat (5) @(posedge clk);
                #1 out_ready[0] = 1'b1;
            end
        join
        drain();

        // Overflow on the 36-bit accumulator.
        send(1, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b0);
        send(1, 18'h3FFFF, 18'h3FFFF, 1'b0, 1'b1);
        send(1, 18'h20000, 18'h20000, 1'b1, 1'b0);
        send(1, 18'h20000, 18'h20000, 1'b1, 1'b1);
        drain();

        // Random traffic with random backpressure on both instances.
        fork
            random_stream(0, 60);
            random_stream(1, 60);
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready[0] = ($urandom_range(0, 3) != 0);
                    out_ready[1] = ($urandom_range(0, 2) != 0);
                end
            end
            begin
                wait (exp_q0.size() > 0);
                repeat (400) @(posedge clk);
            end
        join_any
        // join_any returns when the first stream ends; wait for the rest to settle.
        repeat (300) @(posedge clk);
        rand_done = 1'b1;
        #1;
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        drain();

        // Asynchronous reset with beats in flight.
        send(0, 18'd3, 18'd5, 1'b0, 1'b0);
        drain();
        send(0, 18'd9, 18'd9, 1'b0, 1'b0);
        send(0, 18'd8, 18'd8, 1'b0, 1'b1);
        send(0, 18'd7, 18'd7, 1'b0, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid[0]), 64'(0));
        check("async_rst_data", 64'(out_data0), 64'(0));
        exp_q0.delete();
        exp_q1.delete();
        model_acc[0] = 0;
        model_acc[1] = 0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            check("no_stale", 64'(out_valid[0]), 64'(0));
        end
        send(0, 18'd6, 18'd7, 1'b0, 1'b1);
        k = 0;
        while (!out_valid[0] && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("post_rst_acc", 64'(out_data0), 64'(42));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
